bfly2_pair_buffer: RTL and testbench

- Input reorder stage that sits directly upstream of the radix-2 butterfly (bfly2) in the 32-point IFFT pipeline.
- Accepts one complex sample per cycle in natural order.
- Holds the first half of each 2·SPAN block in an internal buffer.
- When each matching second-half sample arrives, emits the pair (x[k], x[k+SPAN]) on registered outputs that drive the butterfly's di1/di2 inputs directly.

---
 rtl/bfly2_pair_buffer.sv | 94 +++++++++
 tb/tb_bfly2_pair_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bfly2_pair_buffer.sv
// rtl/bfly2_pair_buffer.sv - natural-order input reorder feeding the radix-2 butterfly
// Buffers the first SPAN samples of each block, then emits (x[k], x[k+SPAN]) pairs.
module bfly2_pair_buffer #(
   parameter int W    = 36,
   parameter int N    = 32,
   parameter int SPAN = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sync_clr,
   input  logic         in_valid,
   input  logic [W-1:0] in_r,
   input  logic [W-1:0] in_i,
   output logic         out_valid,
   output logic [W-1:0] do1r,
   output logic [W-1:0] do1i,
   output logic [W-1:0] do2r,
   output logic [W-1:0] do2i,
   output logic [4:0]   pair_idx,
   output logic         frame_done
);

   localparam int CW = $clog2(2 * SPAN);
   localparam int JW = $clog2(SPAN);
   localparam int FW = $clog2(N);

   typedef enum logic {FILL, PAIR} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [FW-1:0]  fcnt;
   logic [2*W-1:0] mem [SPAN];
   logic           accept;
   logic [JW-1:0]  j;
   logic [2*W-1:0] held;

   assign accept = in_valid && !sync_clr;
   // SPAN is a power of two, so the low cnt bits are both the write slot and j.
   assign j      = cnt[JW-1:0];
   assign held   = mem[j];

   always_ff @(posedge clk) begin
      if (accept && state == FILL) begin
         mem[j] <= {in_r, in_i};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= FILL;
         cnt        <= '0;
         fcnt       <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         do1r       <= '0;
         do1i       <= '0;
         do2r       <= '0;
         do2i       <= '0;
         pair_idx   <= '0;
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (sync_clr) begin
            state <= FILL;
            cnt   <= '0;
            fcnt  <= '0;
         end else if (in_valid) begin
            cnt  <= cnt + 1'b1;
            fcnt <= fcnt + 1'b1;
            case (state)
               FILL: begin
                  if (cnt == CW'(SPAN - 1)) begin
                     state <= PAIR;
                  end
               end
               PAIR: begin
                  do1r       <= held[2*W-1:W];
                  do1i       <= held[W-1:0];
                  do2r       <= in_r;
                  do2i       <= in_i;
                  pair_idx   <= 5'(j);
                  out_valid  <= 1'b1;
                  frame_done <= (fcnt == FW'(N - 1));
                  if (cnt == CW'(2 * SPAN - 1)) begin
                     state <= FILL;
                  end
               end
               default: state <= FILL;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bfly2_pair_buffer.sv
// tb/tb_bfly2_pair_buffer.sv - directed bench for bfly2_pair_buffer
// Instance a uses SPAN=16/N=32, instance b uses SPAN=2/N=8.
module tb_bfly2_pair_buffer;

   logic        clk;
   logic        rst;
   logic        sync_clr;
   logic        in_valid;
   logic [35:0] in_r;
   logic [35:0] in_i;
   logic        out_valid;
   logic [35:0] do1r;
   logic [35:0] do1i;
   logic [35:0] do2r;
   logic [35:0] do2i;
   logic [4:0]  pair_idx;
   logic        frame_done;

   logic        b_clr;
   logic        b_valid;
   logic [35:0] b_r;
   logic [35:0] b_i;
   logic        b_out_valid;
   logic [35:0] b_do1r;
   logic [35:0] b_do1i;
   logic [35:0] b_do2r;
   logic [35:0] b_do2i;
   logic [4:0]  b_pair_idx;
   logic        b_frame_done;

   int checks;
   int errors;

   logic [35:0] last_1r, last_1i, last_2r, last_2i;
   logic [4:0]  last_idx;

   bfly2_pair_buffer #(.W(36), .N(32), .SPAN(16)) dut_a (
      .clk(clk), .rst(rst), .sync_clr(sync_clr), .in_valid(in_valid),
      .in_r(in_r), .in_i(in_i), .out_valid(out_valid),
      .do1r(do1r), .do1i(do1i), .do2r(do2r), .do2i(do2i),
      .pair_idx(pair_idx), .frame_done(frame_done)
   );

   bfly2_pair_buffer #(.W(36), .N(8), .SPAN(2)) dut_b (
      .clk(clk), .rst(rst), .sync_clr(b_clr), .in_valid(b_valid),
      .in_r(b_r), .in_i(b_i), .out_valid(b_out_valid),
      .do1r(b_do1r), .do1i(b_do1i), .do2r(b_do2r), .do2i(b_do2i),
      .pair_idx(b_pair_idx), .frame_done(b_frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_a(input logic v, input logic [35:0] r, input logic [35:0] i, input logic clr);
      in_valid = v;
      in_r     = r;
      in_i     = i;
      sync_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_last();
      last_1r  = '0;
      last_1i  = '0;
      last_2r  = '0;
      last_2i  = '0;
      last_idx = '0;
   endtask

   task automatic check_idle(input string tag, input int k);
      checks++;
      if ({out_valid, frame_done, pair_idx, do1r, do1i, do2r, do2i} !==
          {2'b00, last_idx, last_1r, last_1i, last_2r, last_2i}) begin
         errors++;
         $display("FAIL %s idle k=%0d got v=%b fd=%b idx=%0d %h %h %h %h want v=0 fd=0 idx=%0d %h %h %h %h",
                  tag, k, out_valid, frame_done, pair_idx, do1r, do1i, do2r, do2i,
                  last_idx, last_1r, last_1i, last_2r, last_2i);
      end
   endtask

   // Feeds samples 0..n-1 of a frame (value base+k) and checks every cycle.
   task automatic feed(input int n, input logic [35:0] br, input logic [35:0] bi, input bit gaps, input string tag);
      logic exp_fd;
      for (int k = 0; k < n; k++) begin
         drive_a(1'b1, br + 36'(k), bi + 36'(k), 1'b0);
         if (k >= 16) begin
            last_1r  = br + 36'(k - 16);
            last_1i  = bi + 36'(k - 16);
            last_2r  = br + 36'(k);
            last_2i  = bi + 36'(k);
            last_idx = 5'(k - 16);
            exp_fd   = (k == 31);
            checks++;
            if ({out_valid, frame_done, pair_idx, do1r, do1i, do2r, do2i} !==
                {1'b1, exp_fd, last_idx, last_1r, last_1i, last_2r, last_2i}) begin
               errors++;
               $display("FAIL %s pair k=%0d got v=%b fd=%b idx=%0d %h %h %h %h want v=1 fd=%b idx=%0d %h %h %h %h",
                        tag, k, out_valid, frame_done, pair_idx, do1r, do1i, do2r, do2i,
                        exp_fd, last_idx, last_1r, last_1i, last_2r, last_2i);
            end
         end else begin
            check_idle(tag, k);
         end
         if (gaps) begin
            drive_a(1'b0, 36'hFFFF_0000_0, 36'h0_0000_FFFF, 1'b0);
            check_idle({tag, "_gap"}, k);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      b_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         b_r = {4'h0, $urandom};
         b_i = {4'h0, $urandom};
         drive_a(1'b1, {4'h0, $urandom}, {4'h0, $urandom}, 1'b0);
         checks++;
         if ({out_valid, frame_done, pair_idx, do1r, do1i, do2r, do2i,
              b_out_valid, b_frame_done, b_pair_idx, b_do1r, b_do1i, b_do2r, b_do2i} !== '0) begin
            errors++;
            $display("FAIL reset_state c=%0d got a_v=%b a_fd=%b a_idx=%0d a_do1r=%h b_v=%b b_do1r=%h want all 0",
                     c, out_valid, frame_done, pair_idx, do1r, b_out_valid, b_do1r);
         end
      end
      b_valid = 1'b0;
      rst = 1'b1;
      clear_last();
      feed(32, 36'h500, 36'h5A0, 1'b0, "reset_frame");
   endtask

   task automatic test_pairing();
      feed(32, 36'd0, 36'd100, 1'b0, "pairing");
      feed(32, 36'hF_FFFF_FFF0, 36'h8_0000_0000, 1'b0, "pairing_signed");
   endtask

   task automatic test_gaps();
      feed(32, 36'd0, 36'd100, 1'b1, "gaps");
   endtask

   task automatic test_abort();
      feed(10, 36'd0, 36'd0, 1'b0, "pre_abort");
      drive_a(1'b1, 36'hDEAD, 36'hBEEF, 1'b1);
      check_idle("abort_clr", 0);
      feed(32, 36'h100, 36'h200, 1'b0, "post_abort");
      feed(18, 36'h800, 36'h900, 1'b0, "pre_abort_pair");
      drive_a(1'b1, 36'hDEAD, 36'hBEEF, 1'b1);
      check_idle("abort_pair_clr", 0);
      feed(32, 36'hA00, 36'hB00, 1'b0, "post_abort_pair");
   endtask

   task automatic test_async_reset();
      feed(21, 36'h300, 36'h380, 1'b0, "pre_async");
      #2;
      rst = 1'b0;
      #1;
      clear_last();
      checks++;
      if ({out_valid, frame_done, pair_idx, do1r, do1i, do2r, do2i} !== '0) begin
         errors++;
         $display("FAIL async_reset got v=%b fd=%b idx=%0d %h %h %h %h want all 0",
                  out_valid, frame_done, pair_idx, do1r, do1i, do2r, do2i);
      end
      #2;
      rst = 1'b1;
      feed(32, 36'h600, 36'h680, 1'b0, "post_async");
   endtask

   task automatic test_small_span();
      logic        exp_v;
      logic        exp_fd;
      logic [4:0]  exp_idx;
      logic [35:0] exp_1r;
      logic [35:0] exp_2r;
      in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         b_valid = 1'b1;
         b_r     = 36'(k);
         b_i     = 36'(50 + k);
         @(posedge clk);
         #1;
         exp_v = ((k % 4) >= 2);
         if (exp_v) begin
            exp_idx = 5'((k % 4) - 2);
            exp_1r  = 36'(k - 2);
            exp_2r  = 36'(k);
            exp_fd  = ((k % 8) == 7);
            checks++;
            if ({b_out_valid, b_frame_done, b_pair_idx, b_do1r, b_do1i, b_do2r, b_do2i} !==
                {1'b1, exp_fd, exp_idx, exp_1r, exp_1r + 36'd50, exp_2r, exp_2r + 36'd50}) begin
               errors++;
               $display("FAIL small_span k=%0d got v=%b fd=%b idx=%0d %h %h %h %h want fd=%b idx=%0d %h %h",
                        k, b_out_valid, b_frame_done, b_pair_idx, b_do1r, b_do1i, b_do2r, b_do2i,
                        exp_fd, exp_idx, exp_1r, exp_2r);
            end
         end else begin
            checks++;
            if ({b_out_valid, b_frame_done} !== 2'b00) begin
               errors++;
               $display("FAIL small_span_idle k=%0d got v=%b fd=%b want 0 0", k, b_out_valid, b_frame_done);
            end
         end
      end
      b_valid = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b0;
      sync_clr = 1'b0;
      in_valid = 1'b0;
      in_r     = '0;
      in_i     = '0;
      b_clr    = 1'b0;
      b_valid  = 1'b0;
      b_r      = '0;
      b_i      = '0;
      clear_last();
      @(posedge clk);
      #1;
      test_reset();
      test_pairing();
      test_gaps();
      test_abort();
      test_async_reset();
      test_small_span();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
